// File: rtl/regf_mp_pkg.sv
// Shared defaults for the multi-port integer register file of the RV32E NPC core.
package regf_mp_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned REG_NUM   = 16;
  localparam int unsigned A0_IDX    = 10;

endpackage

// File: rtl/regf_mp_if.sv
// Issue/writeback bus of the register file: read ports, write ports and scoreboard set/clear.
interface regf_mp_if
  import regf_mp_pkg::*;
#(
  parameter int unsigned XLEN = CPU_WIDTH,
  parameter int unsigned NREG = REG_NUM,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic [NWR-1:0]      clr_mask;

  modport master (
    output wen, waddr, wdata, raddr, set_en, set_addr, clr_mask,
    input  rdata, rbusy
  );

  modport slave (
    input  wen, waddr, wdata, raddr, set_en, set_addr, clr_mask,
    output rdata, rbusy
  );

endinterface

// File: rtl/regf_mp_wr_arb.sv
// Write-port arbiter for one target register: highest enabled port index wins.
module regf_wr_arb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 4,
  parameter int unsigned NWR  = 1
) (
  input  logic [AW-1:0]       tgt,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan: a later (higher) port overrides any earlier match.
    for (int unsigned p = 0; p < NWR; p++) begin
      if (wen[p] && (waddr[p*AW +: AW] == tgt) && (tgt != '0)) begin
        hit  = 1'b1;
        data = wdata[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/stl_reg.sv
// Generic enabled register with asynchronous active-low reset.
module stl_reg #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/regf_mp.sv
// Multi-port register file with optional write-to-read bypass and a per-register busy scoreboard.
module regf_mp
  import regf_mp_pkg::*;
#(
  parameter int unsigned XLEN   = CPU_WIDTH,
  parameter int unsigned NREG   = REG_NUM,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  regf_mp_if.slave         bus,
  output logic [NREG-1:0]  busy_vec,
`ifdef SIMULATION
  output logic [NREG*XLEN-1:0] flat_rf,
`endif
  output logic             s_a0zero
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic            wr_hit;
    logic [XLEN-1:0] wr_data;
    logic            set_hit;
    logic            clr_hit;

    regf_wr_arb #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_arb (
      .tgt   (AW'(r)),
      .wen   (bus.wen),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .hit   (wr_hit),
      .data  (wr_data)
    );

    stl_reg #(
      .WIDTH (XLEN)
    ) u_data (
      .clk   (clk),
      .rst_n (rst),
      .wen   (wr_hit),
      .din   (wr_data),
      .dout  (regs[r])
    );

    assign set_hit = bus.set_en && (bus.set_addr == AW'(r));

    // Clear is honoured by every enabled port, including ones that lose the data arbitration.
    always_comb begin
      clr_hit = 1'b0;
      for (int unsigned p = 0; p < NWR; p++) begin
        if (bus.wen[p] && bus.clr_mask[p] && (bus.waddr[p*AW +: AW] == AW'(r))) begin
          clr_hit = 1'b1;
        end
      end
    end

    // Set takes priority: a new producer issued while the old one retires stays pending.
    stl_reg #(
      .WIDTH (1)
    ) u_busy (
      .clk   (clk),
      .rst_n (rst),
      .wen   (set_hit | clr_hit),
      .din   (set_hit),
      .dout  (busy[r])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_sel;

    assign ra = bus.raddr[i*AW +: AW];

    if (BYPASS) begin : g_byp
      logic            byp_hit;
      logic [XLEN-1:0] byp_data;

      regf_wr_arb #(
        .XLEN (XLEN),
        .AW   (AW),
        .NWR  (NWR)
      ) u_byp_arb (
        .tgt   (ra),
        .wen   (bus.wen),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .hit   (byp_hit),
        .data  (byp_data)
      );

      // Forwarding is suppressed under reset, since the write will be discarded.
      assign rd_sel = (byp_hit && rst) ? byp_data : regs[ra];
    end else begin : g_nobyp
      assign rd_sel = regs[ra];
    end

    assign bus.rdata[i*XLEN +: XLEN] = (ra == '0) ? '0 : rd_sel;
    assign bus.rbusy[i]              = busy[ra];
  end

  assign busy_vec = busy;

`ifdef SIMULATION
  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign flat_rf[r*XLEN +: XLEN] = regs[r];
  end
`endif

  if (NREG > A0_IDX) begin : g_a0
    assign s_a0zero = ~|regs[A0_IDX];
  end else begin : g_no_a0
    assign s_a0zero = 1'b1;
  end

endmodule

// File: tb/tb_regf_mp.sv
// Scoreboard bench: one bypassing and one non-bypassing register file driven identically.
module tb_regf_mp;
  import regf_mp_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NWR-1:0]      wen;
  logic [NWR-1:0]      clr_mask;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic                set_en;
  logic [AW-1:0]       set_addr;

  regf_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_b ();
  regf_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_n ();

  assign bus_b.wen = wen;       assign bus_n.wen = wen;
  assign bus_b.waddr = waddr;   assign bus_n.waddr = waddr;
  assign bus_b.wdata = wdata;   assign bus_n.wdata = wdata;
  assign bus_b.raddr = raddr;   assign bus_n.raddr = raddr;
  assign bus_b.set_en = set_en; assign bus_n.set_en = set_en;
  assign bus_b.set_addr = set_addr; assign bus_n.set_addr = set_addr;
  assign bus_b.clr_mask = clr_mask; assign bus_n.clr_mask = clr_mask;

  logic [NREG-1:0] busy_b, busy_n;
  logic            a0z_b, a0z_n;
`ifdef SIMULATION
  logic [NREG*XLEN-1:0] flat_b, flat_n;
`endif

  regf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .bus(bus_b), .busy_vec(busy_b),
`ifdef SIMULATION
    .flat_rf(flat_b),
`endif
    .s_a0zero(a0z_b)
  );

  regf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .bus(bus_n), .busy_vec(busy_n),
`ifdef SIMULATION
    .flat_rf(flat_n),
`endif
    .s_a0zero(a0z_n)
  );

  // Reference state: architectural registers and pending-writeback flags.
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] mbusy;

  typedef struct {
    string               tag;
    logic [NRD*XLEN-1:0] rd_b;
    logic [NRD*XLEN-1:0] rd_n;
    logic [NRD-1:0]      rb;
    logic [NREG-1:0]     bv;
    logic                a0z;
    logic [NREG*XLEN-1:0] flat;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int unsigned r = 0; r < NREG; r++) mem[r] = '0;
    mbusy = '0;
  endtask

  function automatic exp_t predict(string tag);
    exp_t e;
    e.tag = tag;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] stored, fwd;
      a = raddr[i*AW +: AW];
      stored = (a == 0) ? '0 : mem[a];
      fwd = stored;
      if (rst) begin
        for (int unsigned p = 0; p < NWR; p++)
          if (wen[p] && waddr[p*AW +: AW] == a && a != 0) fwd = wdata[p*XLEN +: XLEN];
      end
      e.rd_b[i*XLEN +: XLEN] = fwd;
      e.rd_n[i*XLEN +: XLEN] = stored;
      e.rb[i] = mbusy[a];
    end
    e.bv  = mbusy;
    e.a0z = (mem[10] == 0);
    for (int unsigned r = 0; r < NREG; r++) e.flat[r*XLEN +: XLEN] = mem[r];
    return e;
  endfunction

  task automatic commit();
    logic [NREG-1:0] nb;
    if (!rst) return;
    nb = mbusy;
    for (int unsigned p = 0; p < NWR; p++) begin
      logic [AW-1:0] a;
      a = waddr[p*AW +: AW];
      if (wen[p] && a != 0) begin
        if (clr_mask[p]) nb[a] = 1'b0;
      end
    end
    if (set_en && set_addr != 0) nb[set_addr] = 1'b1;
    for (int unsigned p = 0; p < NWR; p++)
      if (wen[p] && waddr[p*AW +: AW] != 0) mem[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
    mbusy = nb;
  endtask

  // Inputs are applied just after a rising edge; the monitor samples them at the falling edge.
  task automatic step(string tag);
    q.push_back(predict(tag));
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic idle();
    wen = '0; clr_mask = '0; waddr = '0; wdata = '0;
    raddr = '0; set_en = 1'b0; set_addr = '0;
  endtask

  task automatic wr(int unsigned p, logic [AW-1:0] a, logic [XLEN-1:0] d, logic clr);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
    clr_mask[p] = clr;
  endtask

  task automatic rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return AW'(10);
      2: return AW'($urandom_range(1, 3));
      default: return AW'($urandom_range(1, NREG - 1));
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".rdata_byp"}, 512'(bus_b.rdata), 512'(e.rd_b));
        chk({e.tag, ".rdata_nobyp"}, 512'(bus_n.rdata), 512'(e.rd_n));
        chk({e.tag, ".rbusy_byp"}, 512'(bus_b.rbusy), 512'(e.rb));
        chk({e.tag, ".rbusy_nobyp"}, 512'(bus_n.rbusy), 512'(e.rb));
        chk({e.tag, ".busy_vec_byp"}, 512'(busy_b), 512'(e.bv));
        chk({e.tag, ".busy_vec_nobyp"}, 512'(busy_n), 512'(e.bv));
        chk({e.tag, ".a0zero_byp"}, 512'(a0z_b), 512'(e.a0z));
        chk({e.tag, ".a0zero_nobyp"}, 512'(a0z_n), 512'(e.a0z));
`ifdef SIMULATION
        chk({e.tag, ".flat_rf"}, 512'(flat_b), 512'(e.flat));
        chk({e.tag, ".flat_rf_nobyp"}, 512'(flat_n), 512'(e.flat));
`endif
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    idle();
    model_clear();
    @(posedge clk);
    #1;

    // Reset asserted while writes and an issue are active
    wr(0, 5, 32'hA5A5_0001, 1'b1);
    wr(1, 10, 32'h0000_0077, 1'b0);
    set_en = 1'b1; set_addr = 3;
    rd(5, 10);
    step("reset_active");
    step("reset_hold");
    rst = 1'b1;
    idle();
    for (int unsigned a = 1; a < NREG; a += 2) begin
      rd(AW'(a), AW'(a + 1));
      step("post_reset_read");
    end

    // Basic write with same-cycle read, then the stored value
    idle(); wr(0, 5, 32'hDEAD_BEEF, 1'b0); rd(5, 0);
    step("write_x5");
    idle(); rd(5, 5);
    step("read_x5");

    // x0 writes and issue are ignored
    idle(); wr(0, 0, 32'h0000_1234, 1'b1); set_en = 1'b1; set_addr = 0; rd(0, 0);
    step("x0_write");
    idle(); rd(0, 5);
    step("x0_read");

    // Both ports on x7: port 1 wins
    idle(); wr(0, 7, 32'h11, 1'b0); wr(1, 7, 32'h22, 1'b0); rd(7, 0);
    step("dual_x7");
    idle(); rd(7, 7);
    step("dual_x7_read");

    // Scoreboard set, clear, and simultaneous set+clear
    idle(); set_en = 1'b1; set_addr = 3; rd(3, 0);
    step("sb_set");
    idle(); rd(3, 0);
    step("sb_busy");
    idle(); wr(0, 3, 32'h33, 1'b1); rd(3, 0);
    step("sb_clr");
    idle(); rd(3, 0);
    step("sb_idle");
    idle(); set_en = 1'b1; set_addr = 3;
    step("sb_set2");
    idle(); wr(0, 3, 32'h34, 1'b1); set_en = 1'b1; set_addr = 3; rd(3, 0);
    step("sb_set_clr");
    idle(); rd(3, 3);
    step("sb_still_busy");
    idle(); wen = '0; clr_mask = 2'b11; waddr = {AW'(3), AW'(3)}; rd(3, 0);
    step("sb_clr_no_wen");
    idle(); wr(0, 3, 32'h55, 1'b1); wr(1, 3, 32'h66, 1'b0); rd(3, 0);
    step("sb_low_port_clr");
    idle(); rd(3, 3);
    step("sb_low_port_read");

    // a0 zero flag
    idle(); wr(0, 10, 32'h5, 1'b0);
    step("a0_w5");
    idle(); wr(1, 10, 32'h0, 1'b0); rd(10, 0);
    step("a0_w0");
    idle(); wr(0, 10, 32'h1, 1'b0); rd(10, 0);
    step("a0_w1");
    idle(); rd(10, 0);
    step("a0_read");

    // Randomized traffic with occasional reset
    for (int unsigned n = 0; n < 600; n++) begin
      idle();
      for (int unsigned p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [XLEN-1:0] d;
          d = ($urandom_range(0, 3) == 0) ? '0 : XLEN'($urandom());
          wr(p, pick_addr(), d, 1'($urandom_range(0, 1)));
        end else begin
          clr_mask[p] = 1'($urandom_range(0, 1));
          waddr[p*AW +: AW] = pick_addr();
        end
      end
      set_en = 1'($urandom_range(0, 1));
      set_addr = pick_addr();
      rd(pick_addr(), pick_addr());
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        model_clear();
        step("rand_reset");
        rst = 1'b1;
      end else begin
        step("rand");
      end
    end

    idle();
    step("drain");
    @(negedge clk);
    #1;
    chk("queue_drain", 512'(q.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regf_mp.md
Name: regf_mp

Overview:
- Parametrised multi-port integer register file for the RV32E NPC core. It generalises the single-write, two-read regfile.
- Adds N read ports, M write ports with defined priority, and optional write-to-read bypass.
- Adds a per-register busy scoreboard for pending writebacks, plus a sim-visibility flat dump.
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

Parameters:
- XLEN, 32, data width per register
- NREG, 16, number of architectural registers (x0 hardwired zero); must be a power of 2
- AW, $clog2(NREG), register address width (derived, not overridden)
- NRD, 2, number of read ports
- NWR, 1, number of write ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads show pre-edge contents

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- wen  in  NWR  per-port write enable
- waddr  in  NWR*AW  packed write addresses, port p at [p*AW +: AW]
- wdata  in  NWR*XLEN  packed write data
- raddr  in  NRD*AW  packed read addresses
- rdata  out  NRD*XLEN  packed read data
- rbusy  out  NRD  busy bit of each read address (scoreboard)
- set_en  in  1  issue marks a destination as pending
- set_addr  in  AW  destination being issued
- clr_mask  in  NWR  per write port: this write retires the pending entry (clears busy)
- busy_vec  out  NREG  full scoreboard, bit 0 always 0
- flat_rf  out  NREG*XLEN  all registers, reg r at [r*XLEN +: XLEN]; only under SIMULATION define
- s_a0zero  out  1  1 when x10 == 0 (sim good/bad trap)

Behaviour:
- Reset (rst=0, async): all registers 0, all busy bits 0, so rdata=0, rbusy=0, s_a0zero=1. Reset mid-write discards that write.
- Register write: on posedge, for each p with wen[p] && waddr[p]!=0, reg[waddr[p]] <= wdata[p].
- Same address on multiple write ports in one cycle: highest port index wins. Lower ports are ignored for data but still honour clr_mask.
- Writes to x0 are dropped. x0 always reads 0, never busy.
- Read is combinational from raddr:
  - BYPASS=1: if any enabled write port targets raddr (nonzero), rdata = winning port's wdata that cycle; else stored value.
  - BYPASS=0: rdata = stored value only (write visible the cycle after the edge).
  - raddr=0 -> rdata=0 in both modes.
- Scoreboard, next-state per register r!=0:
  - busy[r] set if set_en && set_addr==r.
  - Else cleared if any p has wen[p] && clr_mask[p] && waddr[p]==r.
  - Else held.
  - Set and clear on the same r in the same cycle -> set wins (new producer issued while old one retires).
  - set_addr=0 ignored.
  - clr_mask[p] without wen[p] has no effect.
- rbusy[i] = busy[raddr[i]], registered value only (no bypass of the same-cycle clear). Decode retries next cycle.
- s_a0zero = ~|reg[10], from stored contents (no bypass). If NREG<=10, tie s_a0zero to 1.
- No internal FSM beyond the scoreboard. Latency: write -> stored 1 cycle; busy set/clear -> visible 1 cycle.

Decomposition:
- Shared defines file holds XLEN default (CPU_WIDTH), NREG default (REG_NUM), and the A0 index (10).
- One natural sub-module: regf_wr_arb (combinational), per target register producing the winning-port write enable and data, reused by the bypass mux.
- Storage uses the existing stl_reg instance per register, with the reset input adapted to active-low.

Test Plan:
- Reset: rst=0 during active writes -> all rdata=0, busy_vec=0, s_a0zero=1; release, read x1..x15 -> all 0.
- Basic write/read, BYPASS=1: wen[0]=1, waddr=5, wdata=0xDEADBEEF -> rdata same cycle 0xDEADBEEF, next cycle still 0xDEADBEEF. With BYPASS=0 the same-cycle read returns 0.
- x0: write 0x1234 to x0, set_en with set_addr=0 -> raddr=0 reads 0, busy_vec[0]=0.
- Dual write conflict, NWR=2: both ports write x7 (0x11 on p0, 0x22 on p1) -> x7=0x22 next cycle.
- Scoreboard: set x3 -> busy_vec[3]=1 next cycle. Write x3 with clr_mask=1 -> 0. Set and clear x3 in the same cycle -> stays 1.
- a0: write x10=0 then 0x1 -> s_a0zero 1 then 0 one cycle after each edge.
